// File: rtl/hdmi_video_timing.sv
// Free-running CEA 720x576p50 / 720x480p60 raster generator, re-phased onto the source by vreset.
// Define HDMI_TIMING_LOCK_EN to add the locked output and its frame-stability counter.
module hdmi_video_timing #(
   parameter int H_RESET_X   = 0,
   parameter int V_RESET_Y   = 0,
   parameter int LOCK_FRAMES = 4
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       pix_ce,
   input  logic [1:0] mode,
   input  logic       vreset,
   output logic       hs,
   output logic       vs,
   output logic       de,
   output logic [9:0] x,
   output logic [9:0] y,
`ifdef HDMI_TIMING_LOCK_EN
   output logic       frame_start,
   output logic       locked
`else
   output logic       frame_start
`endif
);

   typedef enum logic {MODE_NTSC = 1'b0, MODE_PAL = 1'b1} video_mode_e;

   // Sync windows are stored as [beg, end) so the output decode is two compares.
   typedef struct packed {
      logic [9:0] h_tot;
      logic [9:0] hs_beg;
      logic [9:0] hs_end;
      logic [9:0] v_tot;
      logic [9:0] v_act;
      logic [9:0] vs_beg;
      logic [9:0] vs_end;
   } raster_t;

   localparam logic [9:0] H_ACT   = 10'd720;
   localparam logic [9:0] RESET_X = 10'(H_RESET_X);
   localparam logic [9:0] RESET_Y = 10'(V_RESET_Y);

   function automatic raster_t raster(input video_mode_e m);
      raster_t r;
      if (m == MODE_PAL)
         r = '{h_tot: 10'd864, hs_beg: 10'd732, hs_end: 10'd796,
               v_tot: 10'd625, v_act: 10'd576, vs_beg: 10'd581, vs_end: 10'd586};
      else
         r = '{h_tot: 10'd858, hs_beg: 10'd736, hs_end: 10'd798,
               v_tot: 10'd525, v_act: 10'd480, vs_beg: 10'd489, vs_end: 10'd495};
      return r;
   endfunction

   video_mode_e cur_mode;
   video_mode_e req_mode;
   video_mode_e mode_nxt;
   raster_t     cur_t;
   raster_t     req_t;
   logic [9:0]  hcnt;
   logic [9:0]  vcnt;
   logic [9:0]  hcnt_nxt;
   logic [9:0]  vcnt_nxt;
   logic        vreset_pend;
   logic        load;
   logic        line_end;
   logic        frame_end;

   assign req_mode = (mode == 2'd0) ? MODE_NTSC : MODE_PAL;

   // NOTE: every signal gets a default at the top of always_comb so no path can infer a latch.
   always_comb begin
      cur_t     = raster(cur_mode);
      req_t     = raster(req_mode);
      load      = vreset | vreset_pend;
      line_end  = hcnt >= cur_t.h_tot - 10'd1;
      frame_end = line_end && (vcnt >= cur_t.v_tot - 10'd1);
      hcnt_nxt  = hcnt + 10'd1;
      vcnt_nxt  = vcnt;
      mode_nxt  = cur_mode;
      if (load) begin
         // Load values are clamped against the raster being switched into.
         hcnt_nxt = (RESET_X >= req_t.h_tot) ? '0 : RESET_X;
         vcnt_nxt = (RESET_Y >= req_t.v_tot) ? '0 : RESET_Y;
         mode_nxt = req_mode;
      end else if (line_end) begin
         hcnt_nxt = '0;
         if (frame_end) begin
            vcnt_nxt = '0;
            mode_nxt = req_mode;
         end else begin
            vcnt_nxt = vcnt + 10'd1;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hcnt        <= '0;
         vcnt        <= '0;
         cur_mode    <= MODE_PAL;
         vreset_pend <= 1'b0;
         hs          <= 1'b1;
         vs          <= 1'b1;
         de          <= 1'b0;
         x           <= '0;
         y           <= '0;
         frame_start <= 1'b0;
      end else if (pix_ce) begin
         hcnt        <= hcnt_nxt;
         vcnt        <= vcnt_nxt;
         cur_mode    <= mode_nxt;
         vreset_pend <= 1'b0;
         de          <= (hcnt < H_ACT) && (vcnt < cur_t.v_act);
         hs          <= !((hcnt >= cur_t.hs_beg) && (hcnt < cur_t.hs_end));
         vs          <= !((vcnt >= cur_t.vs_beg) && (vcnt < cur_t.vs_end));
         x           <= hcnt;
         y           <= vcnt;
         frame_start <= (hcnt == '0) && (vcnt == '0);
      end else if (vreset) begin
         vreset_pend <= 1'b1;
      end
   end

`ifdef HDMI_TIMING_LOCK_EN
   logic [2:0] lock_cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         lock_cnt <= '0;
         locked   <= 1'b0;
      end else if (vreset || (pix_ce && vreset_pend)) begin
         lock_cnt <= '0;
         locked   <= 1'b0;
      end else if (pix_ce && frame_end && (lock_cnt != 3'd7)) begin
         lock_cnt <= lock_cnt + 3'd1;
         locked   <= (int'(lock_cnt) + 1) >= LOCK_FRAMES;
      end
   end
`endif

endmodule
